// File: rtl/grf_wb_arbiter_if.sv
// Bundle of GRF write-back arbiter signals: W-stage request, MDU result handshake,
// GRF write port and hazard-unit exports.
interface grf_wb_arbiter_if #(
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          w_en;
  logic [4:0]    w_a3;
  logic [31:0]   w_wd;
  logic [31:0]   w_pc;
  logic          md_valid;
  logic          md_ready;
  logic [4:0]    md_a3;
  logic [31:0]   md_wd;
  logic [31:0]   md_pc;
  logic          stall_w;
  logic          grf_en;
  logic [4:0]    grf_a3;
  logic [31:0]   grf_wd;
  logic [31:0]   grf_pc8;
  logic [31:0]   pending;
  logic [CW-1:0] fifo_cnt;

  // MDU handshake: a result transfers on a rising edge where md_valid && md_ready;
  // md_ready depends only on registered occupancy, never on md_valid.
  modport master (
    output w_en, w_a3, w_wd, w_pc, md_valid, md_a3, md_wd, md_pc,
    input  md_ready, stall_w, grf_en, grf_a3, grf_wd, grf_pc8, pending, fifo_cnt
  );

  modport slave (
    input  w_en, w_a3, w_wd, w_pc, md_valid, md_a3, md_wd, md_pc,
    output md_ready, stall_w, grf_en, grf_a3, grf_wd, grf_pc8, pending, fifo_cnt
  );
endinterface

// File: rtl/grf_wb_arbiter.sv
// Shares the GRF write port between the W stage (priority) and a small MDU result FIFO,
// with a starvation stall. Optional write trace under GRF_WB_TRACE_EN.
module grf_wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input logic            clk,
  input logic            reset,
  grf_wb_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [4:0]       a3_q [DEPTH];
  logic [31:0]      wd_q [DEPTH];
  logic [31:0]      pc_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             stall_q, stall_d;

  logic fifo_ne, w_req, sel_fifo, blocked, push, pop, md_ready;

  assign fifo_ne  = (cnt_q != '0);
  assign w_req    = bus.w_en && (bus.w_a3 != 5'd0);
  // A forced stall hands the port to the head even if W is requesting.
  assign sel_fifo = fifo_ne && (stall_q || !w_req);
  assign pop      = sel_fifo;
  assign blocked  = fifo_ne && !sel_fifo;
  assign md_ready = (cnt_q < CW'(DEPTH));
  assign push     = bus.md_valid && md_ready && (bus.md_a3 != 5'd0);

  assign bus.md_ready = md_ready;
  assign bus.stall_w  = stall_q;
  assign bus.fifo_cnt = cnt_q;

  always_comb begin
    bus.grf_en  = 1'b0;
    bus.grf_a3  = 5'd0;
    bus.grf_wd  = 32'd0;
    bus.grf_pc8 = 32'd0;
    if (sel_fifo) begin
      bus.grf_en  = 1'b1;
      bus.grf_a3  = a3_q[rd_ptr_q];
      bus.grf_wd  = wd_q[rd_ptr_q];
      bus.grf_pc8 = pc_q[rd_ptr_q] + 32'd8;
    end else if (w_req) begin
      bus.grf_en  = 1'b1;
      bus.grf_a3  = bus.w_a3;
      bus.grf_wd  = bus.w_wd;
      bus.grf_pc8 = bus.w_pc + 32'd8;
    end
  end

  always_comb begin
    bus.pending = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) bus.pending[a3_q[i]] = 1'b1;
    end
  end

  always_comb begin
    vld_d    = vld_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PW'(1);
    end
    if (push) begin
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
  end

  // Count consecutive blocked cycles; the stall lands the cycle after the limit is hit.
  always_comb begin
    starve_d = '0;
    stall_d  = 1'b0;
    if (blocked) begin
      if (starve_q == SW'(STARVE_MAX - 1)) stall_d = 1'b1;
      else                                 starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      a3_q[wr_ptr_q] <= bus.md_a3;
      wd_q[wr_ptr_q] <= bus.md_wd;
      pc_q[wr_ptr_q] <= bus.md_pc;
    end
  end

`ifdef GRF_WB_TRACE_EN
  always @(posedge clk) begin
    if (reset && bus.grf_en)
      $display("%d@%h: $%d <= %h", $time, bus.grf_pc8 - 32'd8, bus.grf_a3, bus.grf_wd);
  end
`endif
endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench for grf_wb_arbiter: reset, MDU drain, starvation stall, push/pop, $0 cases.
module tb_grf_wb_arbiter;
  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  grf_wb_arbiter_if #(.DEPTH(2)) bus ();

  grf_wb_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.w_en = 1'b0; bus.w_a3 = 5'd0; bus.w_wd = 32'd0; bus.w_pc = 32'd0;
    bus.md_valid = 1'b0; bus.md_a3 = 5'd0; bus.md_wd = 32'd0; bus.md_pc = 32'd0;
  endtask

  task automatic drive_md(input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
    bus.md_valid = 1'b1; bus.md_a3 = a3; bus.md_wd = wd; bus.md_pc = pc;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    #12;
    n_cmp++;
    if ({bus.fifo_cnt, bus.pending, bus.stall_w, bus.md_ready, bus.grf_en} !== {2'd0, 32'd0, 1'b0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL rst_state: got cnt=%0d pend=%h stall=%b rdy=%b en=%b exp cnt=0 pend=0 stall=0 rdy=1 en=0",
               bus.fifo_cnt, bus.pending, bus.stall_w, bus.md_ready, bus.grf_en);
    end
    bus.w_en = 1'b1; bus.w_a3 = 5'd4; bus.w_wd = 32'h55; bus.w_pc = 32'h200;
    #1;
    n_cmp++;
    if ({bus.grf_en, bus.grf_a3, bus.grf_wd, bus.grf_pc8} !== {1'b1, 5'd4, 32'h55, 32'h208}) begin
      n_bad++;
      $display("FAIL rst_w_path: got en=%b a3=%0d wd=%h pc8=%h exp en=1 a3=4 wd=55 pc8=208",
               bus.grf_en, bus.grf_a3, bus.grf_wd, bus.grf_pc8);
    end
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    next_cycle();
  endtask

  task automatic test_mdu_idle();
    drive_md(5'd5, 32'h1234, 32'h3000);
    @(negedge clk);
    n_cmp++;
    if ({bus.md_ready, bus.grf_en, bus.fifo_cnt} !== {1'b1, 1'b0, 2'd0}) begin
      n_bad++;
      $display("FAIL idle_no_passthru: got rdy=%b en=%b cnt=%0d exp rdy=1 en=0 cnt=0", bus.md_ready, bus.grf_en, bus.fifo_cnt);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if ({bus.grf_en, bus.grf_a3, bus.grf_wd, bus.grf_pc8, bus.fifo_cnt, bus.pending} !==
        {1'b1, 5'd5, 32'h1234, 32'h3008, 2'd1, 32'h20}) begin
      n_bad++;
      $display("FAIL idle_drain: got en=%b a3=%0d wd=%h pc8=%h cnt=%0d pend=%h exp en=1 a3=5 wd=1234 pc8=3008 cnt=1 pend=20",
               bus.grf_en, bus.grf_a3, bus.grf_wd, bus.grf_pc8, bus.fifo_cnt, bus.pending);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({bus.grf_en, bus.fifo_cnt, bus.pending} !== {1'b0, 2'd0, 32'd0}) begin
      n_bad++;
      $display("FAIL idle_after: got en=%b cnt=%0d pend=%h exp en=0 cnt=0 pend=0", bus.grf_en, bus.fifo_cnt, bus.pending);
    end
    next_cycle();
  endtask

  task automatic test_starvation();
    logic [1:0]  exp_cnt [12] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
    logic [31:0] exp_pend [12] = '{32'h0, 32'h80, 32'h280, 32'h280, 32'h280, 32'h280,
                                   32'h200, 32'h200, 32'h200, 32'h200, 32'h200, 32'h0};
    logic        exp_stall;
    logic        exp_rdy;
    logic [4:0]  exp_a3;
    logic [31:0] exp_wd, exp_pc8;
    bus.w_en = 1'b1; bus.w_a3 = 5'd1; bus.w_wd = 32'hAAAA; bus.w_pc = 32'h100;
    for (int c = 0; c < 12; c++) begin
      if (c == 0)      drive_md(5'd7, 32'h77, 32'h700);
      else if (c == 1) drive_md(5'd9, 32'h99, 32'h900);
      else if (c < 5)  drive_md(5'd11, 32'hBB, 32'hB00);
      else begin
        bus.md_valid = 1'b0; bus.md_a3 = 5'd0;
      end
      exp_stall = (c == 5) || (c == 10);
      exp_rdy   = (exp_cnt[c] != 2'd2);
      exp_a3    = (c == 5) ? 5'd7 : (c == 10) ? 5'd9 : 5'd1;
      exp_wd    = (c == 5) ? 32'h77 : (c == 10) ? 32'h99 : 32'hAAAA;
      exp_pc8   = (c == 5) ? 32'h708 : (c == 10) ? 32'h908 : 32'h108;
      @(negedge clk);
      n_cmp++;
      if ({bus.fifo_cnt, bus.pending, bus.stall_w, bus.md_ready} !== {exp_cnt[c], exp_pend[c], exp_stall, exp_rdy}) begin
        n_bad++;
        $display("FAIL starve_state c%0d: got cnt=%0d pend=%h stall=%b rdy=%b exp cnt=%0d pend=%h stall=%b rdy=%b",
                 c, bus.fifo_cnt, bus.pending, bus.stall_w, bus.md_ready, exp_cnt[c], exp_pend[c], exp_stall, exp_rdy);
      end
      n_cmp++;
      if ({bus.grf_en, bus.grf_a3, bus.grf_wd, bus.grf_pc8} !== {1'b1, exp_a3, exp_wd, exp_pc8}) begin
        n_bad++;
        $display("FAIL starve_port c%0d: got en=%b a3=%0d wd=%h pc8=%h exp en=1 a3=%0d wd=%h pc8=%h",
                 c, bus.grf_en, bus.grf_a3, bus.grf_wd, bus.grf_pc8, exp_a3, exp_wd, exp_pc8);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_push_pop();
    drive_md(5'd12, 32'hC, 32'h1200);
    next_cycle();
    drive_md(5'd13, 32'hD, 32'h1300);
    @(negedge clk);
    n_cmp++;
    if ({bus.md_ready, bus.fifo_cnt, bus.grf_en, bus.grf_a3, bus.grf_wd} !== {1'b1, 2'd1, 1'b1, 5'd12, 32'hC}) begin
      n_bad++;
      $display("FAIL pp_same_cycle: got rdy=%b cnt=%0d en=%b a3=%0d wd=%h exp rdy=1 cnt=1 en=1 a3=12 wd=c",
               bus.md_ready, bus.fifo_cnt, bus.grf_en, bus.grf_a3, bus.grf_wd);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if ({bus.fifo_cnt, bus.pending, bus.grf_en, bus.grf_a3, bus.grf_pc8} !== {2'd1, 32'h2000, 1'b1, 5'd13, 32'h1308}) begin
      n_bad++;
      $display("FAIL pp_second: got cnt=%0d pend=%h en=%b a3=%0d pc8=%h exp cnt=1 pend=2000 en=1 a3=13 pc8=1308",
               bus.fifo_cnt, bus.pending, bus.grf_en, bus.grf_a3, bus.grf_pc8);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (bus.fifo_cnt !== 2'd0) begin
      n_bad++;
      $display("FAIL pp_empty: got cnt=%0d exp 0", bus.fifo_cnt);
    end
    next_cycle();
  endtask

  task automatic test_w_zero();
    drive_md(5'd3, 32'h33, 32'h400);
    next_cycle();
    idle_inputs();
    bus.w_en = 1'b1; bus.w_a3 = 5'd0; bus.w_wd = 32'hDEAD; bus.w_pc = 32'h500;
    @(negedge clk);
    n_cmp++;
    if ({bus.grf_en, bus.grf_a3, bus.grf_wd, bus.stall_w} !== {1'b1, 5'd3, 32'h33, 1'b0}) begin
      n_bad++;
      $display("FAIL wzero_drain: got en=%b a3=%0d wd=%h stall=%b exp en=1 a3=3 wd=33 stall=0",
               bus.grf_en, bus.grf_a3, bus.grf_wd, bus.stall_w);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({bus.grf_en, bus.fifo_cnt} !== {1'b0, 2'd0}) begin
      n_bad++;
      $display("FAIL wzero_no_write: got en=%b cnt=%0d exp en=0 cnt=0", bus.grf_en, bus.fifo_cnt);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_md_zero();
    drive_md(5'd0, 32'hFFFF, 32'h600);
    @(negedge clk);
    n_cmp++;
    if (bus.md_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL mdzero_ready: got %b exp 1", bus.md_ready);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if ({bus.fifo_cnt, bus.grf_en, bus.pending} !== {2'd0, 1'b0, 32'd0}) begin
      n_bad++;
      $display("FAIL mdzero_dropped: got cnt=%0d en=%b pend=%h exp cnt=0 en=0 pend=0", bus.fifo_cnt, bus.grf_en, bus.pending);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    bus.w_en = 1'b1; bus.w_a3 = 5'd2; bus.w_wd = 32'h22; bus.w_pc = 32'h800;
    drive_md(5'd4, 32'h44, 32'h840);
    next_cycle();
    drive_md(5'd6, 32'h66, 32'h860);
    next_cycle();
    bus.md_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.fifo_cnt, bus.pending, bus.md_ready} !== {2'd2, 32'h50, 1'b0}) begin
      n_bad++;
      $display("FAIL rmid_pre: got cnt=%0d pend=%h rdy=%b exp cnt=2 pend=50 rdy=0", bus.fifo_cnt, bus.pending, bus.md_ready);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({bus.fifo_cnt, bus.pending, bus.stall_w, bus.md_ready} !== {2'd0, 32'd0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL rmid_async: got cnt=%0d pend=%h stall=%b rdy=%b exp cnt=0 pend=0 stall=0 rdy=1",
               bus.fifo_cnt, bus.pending, bus.stall_w, bus.md_ready);
    end
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if ({bus.fifo_cnt, bus.grf_en, bus.stall_w} !== {2'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL rmid_after: got cnt=%0d en=%b stall=%b exp cnt=0 en=0 stall=0", bus.fifo_cnt, bus.grf_en, bus.stall_w);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_mdu_idle();
    test_md_zero();
    test_starvation();
    test_push_pop();
    test_w_zero();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
